// File: rtl/tree_addr_prefetch_pkg.sv
// Shared definitions for tree_addr_prefetch: CSR bit positions, status/control widths and FSM states.
// The optional same-cycle bypass is enabled with the PREFETCH_BYPASS_EN macro (see tree_addr_prefetch.sv).
package tree_addr_prefetch_pkg;

  localparam int CTRL_W   = 32;
  localparam int STATUS_W = 32;

  localparam int PF_EN_BIT   = 0;
  localparam int STS_EMPTY   = 0;
  localparam int STS_FULL    = 1;
  localparam int STS_EXHAUST = 2;
  localparam int STS_DRAIN   = 3;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_DRAIN    = 2'd2
  } pf_state_e;

endpackage

// File: rtl/tree_addr_prefetch_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the rr pointer;
// the pointer moves past the winner only when a grant is taken (en & advance).
module tree_addr_prefetch_rr_arbiter #(
  parameter int NB_ENG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NB_ENG-1:0] req,
  input  logic              en,
  input  logic              advance,
  output logic [NB_ENG-1:0] grant
);

  localparam int PW = (NB_ENG > 1) ? $clog2(NB_ENG) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NB_ENG; k++) begin
      idx = (int'(ptr_q) + k) % NB_ENG;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        if (advance) ptr_d = PW'((idx + 1) % NB_ENG);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tree_addr_prefetch.sv
// Prefetches free node addresses from tree_space_manager into a small FIFO, hands them to engines
// round-robin, and forwards/returns freed addresses through a skid slice. Macro: PREFETCH_BYPASS_EN.
module tree_addr_prefetch
  import tree_addr_prefetch_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int PF_DEPTH_LOG2  = 2,
  parameter int NB_ENG         = 2
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NB_ENG-1:0]         eng_alloc_valid,
  output logic [NB_ENG-1:0]         eng_alloc_ready,
  output logic [RAM_ADDR_WIDTH-1:0] eng_alloc_addr,
  input  logic                      eng_free_valid,
  output logic                      eng_free_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] eng_free_addr,
  output logic                      mgt_req_valid,
  input  logic                      mgt_req_ready,
  input  logic [RAM_ADDR_WIDTH-1:0] mgt_req_addr,
  output logic                      mgt_free_valid,
  input  logic                      mgt_free_ready,
  output logic [RAM_ADDR_WIDTH-1:0] mgt_free_addr,
  input  logic [CTRL_W-1:0]         csr_slv,
  output logic [STATUS_W-1:0]       csr_mst,
  output pf_state_e                 dbg_state
);

  // Handshakes: a transfer happens on a rising aclk edge where valid and ready are both high;
  // a valid source holds its data stable until that edge.

  localparam int DEPTH = 1 << PF_DEPTH_LOG2;
  localparam int CNT_W = PF_DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PF_DEPTH_LOG2-1:0] PTR_ONE  = PF_DEPTH_LOG2'(1);

  pf_state_e                 state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [RAM_ADDR_WIDTH-1:0] mem_d [DEPTH];
  logic [PF_DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      exh_q, exh_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      out_v_q, out_v_d, skid_v_q, skid_v_d, slice_rdy_q, slice_rdy_d;
  logic [RAM_ADDR_WIDTH-1:0] out_d_q, out_d_d, skid_d_q, skid_d_d;

  logic                      fifo_empty, fifo_full, is_active, is_drain, pf_en, bypass;
  logic                      arb_en, grant_any, push, pop, drain_pop;
  logic                      slice_in_valid, slice_acc, out_pop;
  logic [RAM_ADDR_WIDTH-1:0] fifo_head, slice_in_data;
  logic [NB_ENG-1:0]         arb_grant;
  logic                      csr_unused;

  assign pf_en      = csr_slv[PF_EN_BIT];
  assign csr_unused = ^csr_slv[CTRL_W-1:1];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign fifo_head  = mem_q[rd_ptr_q];
  assign is_active  = (state_q == ST_ACTIVE);
  assign is_drain   = (state_q == ST_DRAIN);
  assign dbg_state  = state_q;

  assign mgt_req_valid = is_active & ~fifo_full;

`ifdef PREFETCH_BYPASS_EN
  // An empty FIFO lets the manager's address go straight to a waiting engine.
  assign bypass = is_active & fifo_empty & mgt_req_ready;
`else
  assign bypass = 1'b0;
`endif

  assign arb_en = is_active & (~fifo_empty | bypass);

  tree_addr_prefetch_rr_arbiter #(.NB_ENG(NB_ENG)) u_arb (
    .clk     (aclk),
    .rst_n   (aresetn),
    .req     (eng_alloc_valid),
    .en      (arb_en),
    .advance (arb_en),
    .grant   (arb_grant)
  );

  assign grant_any       = |arb_grant;
  assign eng_alloc_ready = arb_grant;

  always_comb begin
    eng_alloc_addr = addr_q;
    if (grant_any) eng_alloc_addr = fifo_empty ? mgt_req_addr : fifo_head;
    addr_d = eng_alloc_addr;
  end

  // Free slice input is the engine in normal operation and the FIFO head while draining.
  assign slice_in_valid = is_drain ? ~fifo_empty : eng_free_valid;
  assign slice_in_data  = is_drain ? fifo_head : eng_free_addr;
  assign slice_acc      = slice_in_valid & slice_rdy_q;
  assign eng_free_ready = slice_rdy_q & ~is_drain;
  assign drain_pop      = is_drain & slice_acc;
  assign out_pop        = out_v_q & mgt_free_ready;
  assign mgt_free_valid = out_v_q;
  assign mgt_free_addr  = out_d_q;

  assign push = mgt_req_valid & mgt_req_ready & ~(bypass & grant_any);
  assign pop  = (grant_any & ~fifo_empty) | drain_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = mgt_req_addr;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Ready is registered; the skid entry absorbs the one beat accepted while the output stalls.
  always_comb begin
    out_v_d  = out_v_q;
    out_d_d  = out_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (!out_v_q || out_pop) begin
      if (skid_v_q) begin
        out_v_d  = 1'b1;
        out_d_d  = skid_d_q;
        skid_v_d = 1'b0;
      end else begin
        out_v_d = slice_acc;
        if (slice_acc) out_d_d = slice_in_data;
      end
    end else if (slice_acc) begin
      skid_v_d = 1'b1;
      skid_d_d = slice_in_data;
    end
    slice_rdy_d = ~skid_v_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISABLED: if (pf_en) state_d = ST_ACTIVE;
      ST_ACTIVE:   if (!pf_en) state_d = ST_DRAIN;
      ST_DRAIN:    if (fifo_empty && !out_v_q && !skid_v_q) state_d = ST_DISABLED;
      default:     state_d = ST_DISABLED;
    endcase
    exh_d = exh_q;
    if (is_active && mgt_req_valid && !mgt_req_ready) exh_d = 1'b1;
    if (state_d == ST_DISABLED && state_q != ST_DISABLED) exh_d = 1'b0;
  end

  always_comb begin
    csr_mst              = '0;
    csr_mst[STS_EMPTY]   = fifo_empty;
    csr_mst[STS_FULL]    = fifo_full;
    csr_mst[STS_EXHAUST] = exh_q;
    csr_mst[STS_DRAIN]   = is_drain;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_DISABLED;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      exh_q       <= 1'b0;
      addr_q      <= '0;
      out_v_q     <= 1'b0;
      out_d_q     <= '0;
      skid_v_q    <= 1'b0;
      skid_d_q    <= '0;
      slice_rdy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      exh_q       <= exh_d;
      addr_q      <= addr_d;
      out_v_q     <= out_v_d;
      out_d_q     <= out_d_d;
      skid_v_q    <= skid_v_d;
      skid_d_q    <= skid_d_d;
      slice_rdy_q <= slice_rdy_d;
    end
  end

endmodule

// File: tb/tb_tree_addr_prefetch.sv
// Bench for tree_addr_prefetch: directed phases plus random traffic against a queue-based model
// of the prefetch FIFO, arbitration and exhausted flag, with a scoreboard on the free path.
module tb_tree_addr_prefetch;
  import tree_addr_prefetch_pkg::*;

  localparam int AW = 16;
  localparam int NB = 2;
  localparam int DEPTH = 4;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NB-1:0]     eng_alloc_valid = '0;
  logic [NB-1:0]     eng_alloc_ready;
  logic [AW-1:0]     eng_alloc_addr;
  logic              eng_free_valid = 1'b0;
  logic              eng_free_ready;
  logic [AW-1:0]     eng_free_addr = '0;
  logic              mgt_req_valid;
  logic              mgt_req_ready = 1'b0;
  logic [AW-1:0]     mgt_req_addr = '0;
  logic              mgt_free_valid;
  logic              mgt_free_ready = 1'b0;
  logic [AW-1:0]     mgt_free_addr;
  logic [CTRL_W-1:0] csr_slv = '0;
  logic [STATUS_W-1:0] csr_mst;
  logic [1:0]        dbg_state;

  tree_addr_prefetch #(.RAM_ADDR_WIDTH(AW), .PF_DEPTH_LOG2(2), .NB_ENG(NB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .eng_alloc_valid(eng_alloc_valid), .eng_alloc_ready(eng_alloc_ready), .eng_alloc_addr(eng_alloc_addr),
    .eng_free_valid(eng_free_valid), .eng_free_ready(eng_free_ready), .eng_free_addr(eng_free_addr),
    .mgt_req_valid(mgt_req_valid), .mgt_req_ready(mgt_req_ready), .mgt_req_addr(mgt_req_addr),
    .mgt_free_valid(mgt_free_valid), .mgt_free_ready(mgt_free_ready), .mgt_free_addr(mgt_free_addr),
    .csr_slv(csr_slv), .csr_mst(csr_mst), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // reference model: 0 = disabled, 1 = prefetching, 2 = draining
  int            tests = 0;
  int            fails = 0;
  int            m_state = 0;
  int            m_rr = 0;
  bit            m_exh = 0;
  int            drain_cyc = 0;
  logic [AW-1:0] m_last = '0;
  logic [AW-1:0] mgr_next = '0;
  logic [AW-1:0] m_fifo[$];
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] free_src[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    eng_alloc_valid = '0; eng_free_valid = 1'b0; mgt_req_ready = 1'b0;
    mgt_free_ready = 1'b0; csr_slv = '0;
    #1;
    chk("rst_alloc_ready", eng_alloc_ready, 0);
    chk("rst_alloc_addr", eng_alloc_addr, 0);
    chk("rst_free_ready", eng_free_ready, 0);
    chk("rst_req_valid", mgt_req_valid, 0);
    chk("rst_mfree_valid", mgt_free_valid, 0);
    chk("rst_mfree_addr", mgt_free_addr, 0);
    chk("rst_csr", csr_mst, 32'h1);
    chk("rst_state", dbg_state, ST_DISABLED);
    m_state = 0; m_rr = 0; m_exh = 0; m_last = '0; mgr_next = '0;
    m_fifo.delete(); exp_q.delete(); free_src.delete();
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // driver + checker for one clock cycle
  task automatic step(input logic [NB-1:0] av, input bit mrdy, input bit en, input bit fr_en, input bit mfr);
    int            win;
    bit            byp, can, ereqv;
    logic [NB-1:0] egnt;
    logic [AW-1:0] eaddr;
    logic [31:0]   ecsr;
    @(negedge aclk);
    eng_alloc_valid = av;
    mgt_req_ready   = mrdy;
    mgt_req_addr    = mgr_next;
    csr_slv         = $urandom();
    csr_slv[0]      = en;
    eng_free_valid  = fr_en && (free_src.size() > 0);
    eng_free_addr   = eng_free_valid ? free_src[0] : AW'($urandom());
    mgt_free_ready  = mfr;
    #1;
    if (m_state == 2) begin
      drain_cyc++;
      if (csr_mst[3] === 1'b0 || drain_cyc > 40) begin
        chk("drain_in_time", drain_cyc <= 40, 1);
        chk("drain_all_freed", exp_q.size(), 0);
        exp_q.delete();
        m_state = 0;
        m_exh = 0;
      end
    end
    ereqv = (m_state == 1) && (m_fifo.size() < DEPTH);
    win = -1; byp = 0; egnt = '0; eaddr = m_last;
    if (m_state == 1) begin
      can = (m_fifo.size() > 0);
`ifdef PREFETCH_BYPASS_EN
      if (!can && mrdy) begin can = 1; byp = 1; end
`endif
      if (can)
        for (int k = 0; k < NB; k++)
          if (win < 0 && av[(m_rr + k) % NB]) win = (m_rr + k) % NB;
      if (win >= 0) begin
        egnt[win] = 1'b1;
        eaddr = byp ? mgr_next : m_fifo[0];
      end
    end
    chk("alloc_ready", eng_alloc_ready, egnt);
    chk("alloc_addr", eng_alloc_addr, eaddr);
    chk("req_valid", mgt_req_valid, ereqv);
    if (m_state == 2) begin
      chk("drain_free_ready", eng_free_ready, 0);
      chk("drain_exhaust", csr_mst[2], m_exh);
    end else begin
      ecsr = {28'b0, 1'b0, m_exh, m_fifo.size() == DEPTH, m_fifo.size() == 0};
      chk("csr_mst", csr_mst, ecsr);
    end
    // scoreboard on the free path
    if (eng_free_valid && eng_free_ready) begin
      exp_q.push_back(eng_free_addr);
      void'(free_src.pop_front());
    end
    if (mgt_free_valid && mgt_free_ready) begin
      if (exp_q.size() == 0) chk("mfree_unexpected", mgt_free_valid, 0);
      else chk("mfree_addr", mgt_free_addr, exp_q.pop_front());
    end
    // model update for the coming edge
    if (ereqv && !mrdy) m_exh = 1;
    if (win >= 0 && !byp) void'(m_fifo.pop_front());
    if (ereqv && mrdy) begin
      if (!(byp && win >= 0)) m_fifo.push_back(mgr_next);
      mgr_next++;
    end
    if (win >= 0) begin
      m_rr = (win + 1) % NB;
      m_last = eaddr;
    end
    if (m_state == 0 && en) m_state = 1;
    else if (m_state == 1 && !en) begin
      m_state = 2;
      drain_cyc = 0;
      while (m_fifo.size() > 0) exp_q.push_back(m_fifo.pop_front());
    end
  endtask

  initial begin
    do_reset();
    // fill to full with manager always ready
    for (int i = 0; i < 7; i++) step(2'b00, 1, 1, 0, 1);
    // both engines: alternating grants 0..3, refill behind
    for (int i = 0; i < 8; i++) step(2'b11, 1, 1, 0, 1);
    // manager dries up: drain FIFO, exhausted sets, then resumes
    for (int i = 0; i < 8; i++) step(2'b11, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) step(2'b11, 1, 1, 0, 1);
    // free stream with toggling manager ready
    free_src = '{16'd10, 16'd11, 16'd12};
    for (int i = 0; i < 12; i++) step(2'b00, 1, 1, 1, (i % 2) == 0);
    // drain with 4 prefetched addresses, engine frees held off meanwhile
    for (int i = 0; i < 6; i++) step(2'b00, 1, 1, 0, 1);
    free_src = '{16'd50, 16'd51};
    for (int i = 0; i < 45 && !(i > 0 && m_state == 0); i++) step(2'b00, 1, 0, 1, $urandom_range(0, 1));
    chk("drain_finished", m_state, 0);
    for (int i = 0; i < 8; i++) step(2'b00, 1, 0, 1, 1);
`ifdef PREFETCH_BYPASS_EN
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b00, 0, 1, 0, 1);
    mgr_next = 16'd7;
    step(2'b01, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(2'b00, 0, 1, 0, 1);
`endif
    // random traffic, with a reset in the middle
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 3) == 0 && free_src.size() < 4) free_src.push_back(AW'($urandom()));
        step(NB'($urandom()), $urandom_range(0, 4) != 0, $urandom_range(0, 24) != 0, 1, $urandom_range(0, 2) != 0);
      end
      if (r == 0) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
